// File: rtl/stream_extremum_tracker_pkg.sv
// Shared definitions for the stream extremum tracker: FSM state encoding and sample width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stream_extremum_tracker_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,  // no sample of the current frame seen yet
    S_ACCUM = 2'd1,  // at least one sample accumulated
    S_HOLD  = 2'd2   // frame result presented, waiting for consumer
  } state_t;

endpackage

// File: rtl/stream_extremum_tracker_cmp.sv
// Comparator16Bit: signed 16-bit magnitude comparator producing gt/eq/lt of a versus b.
// Latency: purely combinational.
// Backpressure: none (no handshake).
// Ports: a, b - signed operands; gt/eq/lt - exactly one is high.
module Comparator16Bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        gt,
  output logic        eq,
  output logic        lt
);

  assign gt = ($signed(a) > $signed(b));
  assign lt = ($signed(a) < $signed(b));
  assign eq = (a == b);

endmodule

// File: rtl/stream_extremum_tracker.sv
// Tracks per-frame max/min (signed), their first-occurrence indices and sample count.
// Latency: result valid the cycle after the accept carrying in_last.
// Backpressure: in_ready low while a result is held; one bubble cycle after handoff.
// Ports: clk/rst (sync, active-high); in_valid/in_data/in_last/in_ready sample stream;
//        out_valid/out_ready result handshake; out_max/out_min/out_max_idx/out_min_idx/out_count result.
module stream_extremum_tracker
  import stream_extremum_tracker_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_max,
  output logic [DATA_W-1:0] out_min,
  output logic [CNT_W-1:0]  out_max_idx,
  output logic [CNT_W-1:0]  out_min_idx,
  output logic [CNT_W-1:0]  out_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state_q, state_d;

  // running accumulators for the frame in progress
  logic [DATA_W-1:0] max_q, max_d;
  logic [DATA_W-1:0] min_q, min_d;
  logic [CNT_W-1:0]  max_idx_q, max_idx_d;
  logic [CNT_W-1:0]  min_idx_q, min_idx_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic accept;
  logic frame_done;

  logic max_gt, max_eq, max_lt;
  logic min_gt, min_eq, min_lt;
  logic unused_cmp;

  Comparator16Bit cmp_max (
    .a  (in_data),
    .b  (max_q),
    .gt (max_gt),
    .eq (max_eq),
    .lt (max_lt)
  );

  Comparator16Bit cmp_min (
    .a  (in_data),
    .b  (min_q),
    .gt (min_gt),
    .eq (min_eq),
    .lt (min_lt)
  );

  // only strict improvements matter; equal values keep the first occurrence
  assign unused_cmp = &{1'b0, max_eq, max_lt, min_gt, min_eq};

  assign accept     = in_valid && in_ready;
  assign frame_done = accept && in_last;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (accept) state_d = in_last ? S_HOLD : S_ACCUM;
      S_ACCUM: if (accept && in_last) state_d = S_HOLD;
      S_HOLD:  if (out_ready) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = !rst && (state_q != S_HOLD);
    out_valid = (state_q == S_HOLD);
  end

  // ---------------- accumulator next values ----------------
  always_comb begin
    max_d     = max_q;
    min_d     = min_q;
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;
    count_d   = count_q;
    if (accept) begin
      if (state_q == S_EMPTY) begin
        max_d     = in_data;
        min_d     = in_data;
        max_idx_d = '0;
        min_idx_d = '0;
        count_d   = CNT_W'(1);
      end else begin
        // count_q is the 0-based index of this sample, already clamped at saturation
        if (max_gt) begin
          max_d     = in_data;
          max_idx_d = count_q;
        end
        if (min_lt) begin
          min_d     = in_data;
          min_idx_d = count_q;
        end
        count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
      count_q   <= '0;
    end else begin
      max_q     <= max_d;
      min_q     <= min_d;
      max_idx_q <= max_idx_d;
      min_idx_q <= min_idx_d;
      count_q   <= count_d;
    end
  end

  // ---------------- result registers ----------------
  // Loaded only on frame completion so the last result survives until the next frame ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_max     <= '0;
      out_min     <= '0;
      out_max_idx <= '0;
      out_min_idx <= '0;
      out_count   <= '0;
    end else if (frame_done) begin
      out_max     <= max_d;
      out_min     <= min_d;
      out_max_idx <= max_idx_d;
      out_min_idx <= min_idx_d;
      out_count   <= count_d;
    end
  end

endmodule

// File: tb/tb_stream_extremum_tracker.sv
module tb_stream_extremum_tracker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;

  logic        in_ready_a, out_valid_a;
  logic [15:0] out_max_a, out_min_a;
  logic [7:0]  out_max_idx_a, out_min_idx_a, out_count_a;

  logic        in_ready_b, out_valid_b;
  logic [15:0] out_max_b, out_min_b;
  logic [2:0]  out_max_idx_b, out_min_idx_b, out_count_b;

  int n_vec = 0;
  int n_err = 0;
  bit hold_low = 1'b1;

  typedef struct packed {
    logic [15:0] mx;
    logic [15:0] mn;
    int mxi;
    int mni;
    int cnt;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  stream_extremum_tracker #(.CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_max(out_max_a), .out_min(out_min_a), .out_max_idx(out_max_idx_a),
    .out_min_idx(out_min_idx_a), .out_count(out_count_a)
  );

  stream_extremum_tracker #(.CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_max(out_max_b), .out_min(out_min_b), .out_max_idx(out_max_idx_b),
    .out_min_idx(out_min_idx_b), .out_count(out_count_b)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference: scan the whole frame, keep strictly-better values; indices and count clamp at 2**w-1.
  function automatic exp_t model(input logic [15:0] s[$], input int w);
    exp_t e;
    int sat;
    int bi;
    int li;
    sat = (1 << w) - 1;
    e.mx = s[0];
    e.mn = s[0];
    bi = 0;
    li = 0;
    for (int i = 1; i < s.size(); i++) begin
      if ($signed(s[i]) > $signed(e.mx)) begin e.mx = s[i]; bi = i; end
      if ($signed(s[i]) < $signed(e.mn)) begin e.mn = s[i]; li = i; end
    end
    e.mxi = (bi > sat) ? sat : bi;
    e.mni = (li > sat) ? sat : li;
    e.cnt = (s.size() > sat) ? sat : s.size();
    return e;
  endfunction

  // Drives one frame; gap_pct inserts idle cycles with junk data/last on in_valid=0.
  task automatic send_frame(input logic [15:0] s[$], input int gap_pct);
    qa.push_back(model(s, 8));
    qb.push_back(model(s, 3));
    for (int i = 0; i < s.size(); i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_last  = 1'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = s[i];
      in_last  = (i == s.size() - 1);
      begin
        int w = 0;
        while (!in_ready_a) begin
          @(posedge clk); #1;
          w++;
          if (w > 500) begin
            chk("in_ready_timeout", 0, 1);
            break;
          end
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("latency_out_valid", out_valid_a, 1);
  endtask

  task automatic drain();
    int w = 0;
    while ((qa.size() != 0 || qb.size() != 0) && w < 3000) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain_queue_empty", qa.size() + qb.size(), 0);
  endtask

  // consumer readiness, randomized unless the test forces back-pressure
  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // monitor: handshake checks and scoreboard pops
  logic        prev_stall = 1'b0;
  logic        prev_hand  = 1'b0;
  logic [15:0] snap_max, snap_min;
  logic [7:0]  snap_mxi, snap_mni, snap_cnt;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("in_ready_in_rst", in_ready_a, 0);
        prev_stall = 1'b0;
        prev_hand  = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_max_stable", out_max_a, snap_max);
          chk("stall_min_stable", out_min_a, snap_min);
          chk("stall_idx_stable", {out_max_idx_a, out_min_idx_a, out_count_a},
              {snap_mxi, snap_mni, snap_cnt});
        end
        if (prev_hand) begin
          chk("bubble_out_valid_low", out_valid_a, 0);
          chk("bubble_in_ready_high", in_ready_a, 1);
        end
        prev_stall = 1'b0;
        prev_hand  = 1'b0;
        chk("in_ready_b_matches_a", in_ready_b, in_ready_a);
        if (out_valid_a) begin
          chk("in_ready_low_in_hold", in_ready_a, 0);
          if (out_ready) begin
            prev_hand = 1'b1;
            if (qa.size() == 0) chk("unexpected_result_a", 1, 0);
            else begin
              e = qa.pop_front();
              chk("a_max", out_max_a, e.mx);
              chk("a_min", out_min_a, e.mn);
              chk("a_max_idx", out_max_idx_a, e.mxi);
              chk("a_min_idx", out_min_idx_a, e.mni);
              chk("a_count", out_count_a, e.cnt);
            end
            if (!out_valid_b || qb.size() == 0) chk("unexpected_result_b", 1, 0);
            else begin
              e = qb.pop_front();
              chk("b_max", out_max_b, e.mx);
              chk("b_min", out_min_b, e.mn);
              chk("b_max_idx", out_max_idx_b, e.mxi);
              chk("b_min_idx", out_min_idx_b, e.mni);
              chk("b_count", out_count_b, e.cnt);
            end
          end else begin
            prev_stall = 1'b1;
            snap_max = out_max_a;
            snap_min = out_min_a;
            snap_mxi = out_max_idx_a;
            snap_mni = out_min_idx_a;
            snap_cnt = out_count_a;
          end
        end
      end
    end
  end

  initial begin
    logic [15:0] s[$];

    // reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_out_max", out_max_a, 0);
    chk("rst_out_min", out_min_a, 0);
    chk("rst_out_cnt", {out_max_idx_a, out_min_idx_a, out_count_a}, 0);
    chk("rst_in_ready", in_ready_a, 1);
    @(posedge clk); #1;
    hold_low = 1'b0;

    // directed frames
    s = '{16'd5, 16'hFFFD, 16'd12, 16'd12, 16'hFFFD, 16'd0};
    send_frame(s, 0);
    s = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000};
    send_frame(s, 0);
    s = '{16'hFFFF};
    send_frame(s, 0);
    s = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10};
    send_frame(s, 40);
    s = '{16'd3, 16'hFFF0, 16'd3, 16'd20, 16'hFFF0, 16'd20};
    send_frame(s, 50);
    drain();

    // back-pressure: result held, in_valid presented but ignored
    hold_low = 1'b1;
    @(posedge clk); #1;
    s = '{16'd9, 16'h8001, 16'd100};
    send_frame(s, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h1234;
      in_last  = 1'b1;
      @(posedge clk); #1;
    end
    chk("bp_still_valid", out_valid_a, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    hold_low = 1'b0;
    s = '{16'd4, 16'd4};
    send_frame(s, 0);
    drain();

    // mid-frame reset discards the partial frame and clears outputs
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i * 7 + 1);
      in_last  = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", out_valid_a, 0);
    chk("midrst_out_max", out_max_a, 0);
    chk("midrst_out_count", out_count_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready_after", in_ready_a, 1);
    @(posedge clk); #1;
    s = '{16'd50, 16'hFFCE};
    send_frame(s, 0);

    // random frames: some with narrow ranges for duplicates, some long enough to saturate
    for (int f = 0; f < 25; f++) begin
      int len;
      int narrow;
      s = {};
      len = (f % 5 == 4) ? $urandom_range(250, 300) : $urandom_range(1, 40);
      narrow = $urandom_range(0, 1);
      for (int i = 0; i < len; i++)
        s.push_back(narrow ? 16'($urandom_range(0, 7) - 4) : 16'($urandom));
      send_frame(s, $urandom_range(0, 30));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
